spr_arb: RTL
============

SPR_ARB -- requirements
Module: spr_arb

Interface
REQ-001 SHALL have parameter AW, default 14, meaning RAM address width (matches the shared single-port RAM).
REQ-002 SHALL have parameter MAXW, default 3, meaning the maximum number of cycles a CPU request may be refused.
REQ-003 SHALL have ports (one per line, name direction width meaning):
  clock  in  1  single system clock, rising edge
  reset  in  1  asynchronous, active-low reset
  ce     in  1  clock enable; all arbitration and pipeline advance only when high
  vreq   in  1  video read request, held until vgnt
  va     in  AW  video address
  vgnt   out 1  video grant (combinational, this cycle)
  vvalid out 1  video read data valid, one-cycle pulse
  vdo    out 8  video read data
  creq   in  1  CPU request, held with cwr/ca/cdi stable until cgnt
  cwr    in  1  1 = write, 0 = read
  ca     in  AW  CPU address
  cdi    in  8  CPU write data
  cgnt   out 1  CPU grant (combinational, this cycle)
  cack   out 1  CPU completion, one-cycle pulse
  cdo    out 8  CPU read data
  ram_ce out 1  RAM clock enable
  ram_we out 1  RAM write strobe, active-low (0 = write, 1 = read)
  ram_a  out AW  RAM address
  ram_di out 8  RAM write data
  ram_do in  8  RAM read data, valid the cycle after the read edge

Function
REQ-004 SHALL grant at most one requester per cycle; vgnt and cgnt SHALL never be high together.
REQ-005 SHALL grant nothing and hold ram_ce=0 while ce=0; counter and tag pipeline SHALL freeze while ce=0.
REQ-006 SHALL give video priority when both request, unless the wait counter equals MAXW, in which case CPU wins.
REQ-007 SHALL maintain a wait counter: increment on each ce cycle with creq=1 and cgnt=0; clear on cgnt or creq=0; saturate at MAXW.
REQ-008 SHALL, in grant cycle c, drive ram_ce=1, ram_a, ram_di=cdi, ram_we=0 for a CPU write, and ram_we=1 for any read; ram_ce=0 when no grant.
REQ-009 SHALL carry a 2-stage tag pipeline (NONE/VID/CPURD/CPUWR) advancing on ce edges.
REQ-010 SHALL pulse cack in cycle c+1 for a CPU write granted in cycle c (ce continuously high).
REQ-011 SHALL, for reads granted in cycle c, register ram_do at the end of cycle c+1 and present vdo/vvalid or cdo/cack in cycle c+2.
REQ-012 SHALL hold vdo and cdo at their last captured values between pulses.
REQ-013 SHALL accept a new grant every cycle (fully pipelined); back-to-back reads return in grant order.
REQ-014 SHALL treat a requester changing address or data without a grant as a new request; no command is latched before grant.

Reset
REQ-015 SHALL, on reset low, asynchronously clear: wait counter=0, both tag stages=NONE, vvalid=0, cack=0, vdo=0, cdo=0.
REQ-016 SHALL discard in-flight accesses on reset; no vvalid or cack pulse follows reset for a pre-reset grant.
REQ-017 SHALL drive ram_ce=0 and vgnt=cgnt=0 while reset is low.

Structure
REQ-018 SHALL place tag encodings (NONE, VID, CPURD, CPUWR) and the MAXW default in the shared project package.
REQ-019 SHALL be a single module with no sub-modules; the parent instantiates the RAM and wires ram_* to it.

Verification
REQ-020 Video read: vreq=1, va=0x0100 (RAM holds 0x5A) -> vgnt in cycle c, vvalid=1 and vdo=0x5A in c+2.
REQ-021 CPU write then read: write ca=0x0200, cdi=0xA5 -> cack in c+1; read 0x0200 -> cack and cdo=0xA5 two cycles after its grant.
REQ-022 Contention: vreq and creq held high from cycle 0 -> vgnt cycles 0-2, cgnt cycle 3, vgnt cycle 4; pattern repeats.
REQ-023 ce gating: ce=0 for 2 cycles mid-read -> no grants, counter and tags frozen; vvalid delayed by exactly 2 cycles.
REQ-024 Reset mid-operation: reset low in cycle c+1 after a CPU read grant -> no cack; all outputs 0 immediately.
REQ-025 Back-to-back: video reads 0x0000-0x0003 on consecutive cycles -> four consecutive vvalid pulses, data in address order.

Source files
------------

// File: rtl/spr_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: access tags and parameter defaults.
package spr_arb_pkg;

    localparam int unsigned AW_DEFAULT   = 14;
    localparam int unsigned MAXW_DEFAULT = 3;
    localparam int unsigned DW           = 8;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_VID   = 2'd1,
        TAG_CPURD = 2'd2,
        TAG_CPUWR = 2'd3
    } tag_e;

    // Tag for the access granted this cycle, if any.
    function automatic tag_e grant_tag(input logic vgnt, input logic cgnt, input logic cwr);
        tag_e t;
        t = TAG_NONE;
        if (vgnt) begin
            t = TAG_VID;
        end else if (cgnt) begin
            t = cwr ? TAG_CPUWR : TAG_CPURD;
        end
        return t;
    endfunction

endpackage

// File: rtl/spr_arb.sv
// Video/CPU arbiter for a shared single-port RAM: video-first priority with a bounded
// CPU wait, fully pipelined reads returning two cycles after grant.
module spr_arb
    import spr_arb_pkg::*;
#(
    parameter int unsigned AW   = AW_DEFAULT,
    parameter int unsigned MAXW = MAXW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic          vgnt,
    output logic          vvalid,
    output logic [7:0]    vdo,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cdi,
    output logic          cgnt,
    output logic          cack,
    output logic [7:0]    cdo,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_di,
    input  logic [7:0]    ram_do
);

    localparam int unsigned WW = (MAXW < 1) ? 1 : $clog2(MAXW + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAXW);

    logic [WW-1:0] wcnt_q, wcnt_d;
    tag_e          tag1_q, tag1_d;
    tag_e          tag2_q, tag2_d;
    tag_e          gnt_tag;
    logic          vvalid_q, vvalid_d;
    logic          cack_q, cack_d;
    logic [DW-1:0] vdo_q, vdo_d;
    logic [DW-1:0] cdo_q, cdo_d;
    logic          cpu_turn;

    // Grant decision and RAM command for this cycle; nothing is latched before grant.
    always_comb begin
        vgnt     = 1'b0;
        cgnt     = 1'b0;
        cpu_turn = (wcnt_q == WMAX);
        if (reset && ce) begin
            if (creq && (!vreq || cpu_turn)) begin
                cgnt = 1'b1;
            end else if (vreq) begin
                vgnt = 1'b1;
            end
        end
        gnt_tag = grant_tag(vgnt, cgnt, cwr);
        ram_ce  = vgnt | cgnt;
        ram_we  = !(cgnt && cwr);
        ram_a   = cgnt ? ca : va;
        ram_di  = cdi;
    end

    // Wait counter, tag pipeline and result capture; everything holds while ce is low.
    // A CPU write granted right after a CPU read completes in the same cycle, so both
    // completions share one cack pulse.
    always_comb begin
        wcnt_d   = wcnt_q;
        tag1_d   = tag1_q;
        tag2_d   = tag2_q;
        vvalid_d = 1'b0;
        cack_d   = 1'b0;
        vdo_d    = vdo_q;
        cdo_d    = cdo_q;
        if (ce) begin
            if (!creq || cgnt) begin
                wcnt_d = '0;
            end else if (wcnt_q != WMAX) begin
                wcnt_d = wcnt_q + WW'(1);
            end
            tag1_d   = gnt_tag;
            tag2_d   = tag1_q;
            vvalid_d = (tag2_d == TAG_VID);
            cack_d   = (tag1_d == TAG_CPUWR) || (tag2_d == TAG_CPURD);
            if (tag2_d == TAG_VID) begin
                vdo_d = ram_do;
            end
            if (tag2_d == TAG_CPURD) begin
                cdo_d = ram_do;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt_q   <= '0;
            tag1_q   <= TAG_NONE;
            tag2_q   <= TAG_NONE;
            vvalid_q <= 1'b0;
            cack_q   <= 1'b0;
            vdo_q    <= '0;
            cdo_q    <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            vvalid_q <= vvalid_d;
            cack_q   <= cack_d;
            vdo_q    <= vdo_d;
            cdo_q    <= cdo_d;
        end
    end

    assign vvalid = vvalid_q;
    assign vdo    = vdo_q;
    assign cack   = cack_q;
    assign cdo    = cdo_q;

endmodule
